// File: rtl/parity_stream_checker.sv
// Parity stream checker: accepts words with a parity bit over a valid/ready
// stream, flags parity mismatches in a single-slot output register and keeps
// saturating statistics (word count, error count, sticky error flag).
module parity_stream_checker #(
    parameter int DATA_W     = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_parity,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_error,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count,
    input  logic              clr_stats
);

    localparam logic             LP_ODD     = (ODD_PARITY != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] LP_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_CNT_ZERO = {CNT_W{1'b0}};

    // 1 when the word/parity pair violates the configured parity sense
    function automatic logic f_parity_error(input logic [DATA_W-1:0] data,
                                            input logic              parity);
        return (^data) ^ parity ^ LP_ODD;
    endfunction

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] value);
        if (value == LP_CNT_MAX) begin
            return value;
        end else begin
            return value + LP_CNT_ONE;
        end
    endfunction

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_error;
    logic              r_err_sticky;
    logic [CNT_W-1:0]  r_err_count;
    logic [CNT_W-1:0]  r_word_count;

    logic              w_ready;
    logic              w_accept;
    logic              w_error;
    logic              w_sticky_base;
    logic [CNT_W-1:0]  w_err_base;
    logic [CNT_W-1:0]  w_word_base;
    logic              w_sticky_next;
    logic [CNT_W-1:0]  w_err_next;
    logic [CNT_W-1:0]  w_word_next;

    // The slot can take a word when empty or when it is being drained this cycle
    assign w_ready  = !r_out_valid || out_ready;
    assign w_accept = in_valid && w_ready;
    assign w_error  = f_parity_error(in_data, in_parity);

    // Next statistics: a clear is applied first so a coincident word counts afterwards
    always_comb begin
        w_sticky_base = r_err_sticky;
        w_err_base    = r_err_count;
        w_word_base   = r_word_count;
        if (clr_stats) begin
            w_sticky_base = 1'b0;
            w_err_base    = LP_CNT_ZERO;
            w_word_base   = LP_CNT_ZERO;
        end else begin
            w_sticky_base = r_err_sticky;
            w_err_base    = r_err_count;
            w_word_base   = r_word_count;
        end

        w_sticky_next = w_sticky_base;
        w_err_next    = w_err_base;
        w_word_next   = w_word_base;
        if (w_accept) begin
            w_word_next = f_sat_inc(w_word_base);
            if (w_error) begin
                w_err_next    = f_sat_inc(w_err_base);
                w_sticky_next = 1'b1;
            end else begin
                w_err_next    = w_err_base;
                w_sticky_next = w_sticky_base;
            end
        end else begin
            w_word_next   = w_word_base;
            w_err_next    = w_err_base;
            w_sticky_next = w_sticky_base;
        end
    end

    // Output slot: load on acceptance, empty when drained, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {DATA_W{1'b0}};
            r_out_error <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_error <= w_error;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= LP_CNT_ZERO;
            r_word_count <= LP_CNT_ZERO;
        end else begin
            r_err_sticky <= w_sticky_next;
            r_err_count  <= w_err_next;
            r_word_count <= w_word_next;
        end
    end

    assign in_ready   = w_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_error  = r_out_error;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Scoreboard bench for parity_stream_checker: three instances (even/8-bit
// counters, odd/8-bit counters, even/2-bit counters) share one stimulus stream.
module tb_parity_stream_checker;

    typedef struct {
        logic [7:0] data;
        logic       err_even;
    } item_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_parity;
    logic       out_ready;
    logic       clr_stats;

    logic       ir_e, ov_e, oe_e, st_e;
    logic [7:0] od_e, ec_e, wc_e;
    logic       ir_o, ov_o, oe_o, st_o;
    logic [7:0] od_o, ec_o, wc_o;
    logic       ir_s, ov_s, oe_s, st_s;
    logic [7:0] od_s;
    logic [1:0] ec_s, wc_s;

    int    errors = 0;
    int    checks = 0;
    item_t q[$];
    int    words = 0;
    int    errs_e = 0;
    int    errs_o = 0;
    bit    started = 1'b0;
    logic  cons;

    parity_stream_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(8)) u_even (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_e),
        .in_data(in_data), .in_parity(in_parity), .out_valid(ov_e),
        .out_ready(out_ready), .out_data(od_e), .out_error(oe_e),
        .err_sticky(st_e), .err_count(ec_e), .word_count(wc_e),
        .clr_stats(clr_stats));

    parity_stream_checker #(.DATA_W(8), .ODD_PARITY(1), .CNT_W(8)) u_odd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_o),
        .in_data(in_data), .in_parity(in_parity), .out_valid(ov_o),
        .out_ready(out_ready), .out_data(od_o), .out_error(oe_o),
        .err_sticky(st_o), .err_count(ec_o), .word_count(wc_o),
        .clr_stats(clr_stats));

    parity_stream_checker #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_s),
        .in_data(in_data), .in_parity(in_parity), .out_valid(ov_s),
        .out_ready(out_ready), .out_data(od_s), .out_error(oe_s),
        .err_sticky(st_s), .err_count(ec_s), .word_count(wc_s),
        .clr_stats(clr_stats));

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Drive one cycle of stimulus and update the reference model for the coming edge
    task automatic step(input logic v, input logic [7:0] d, input logic p,
                        input logic ordy, input logic clr, input logic r);
        logic  exp_rdy;
        logic  e;
        item_t it;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_parity = p;
        out_ready = ordy;
        clr_stats = clr;
        rst       = r;
        #1;
        exp_rdy = (q.size() == 0) || ordy;
        if (started) begin
            chk("in_ready_even", {63'd0, ir_e}, {63'd0, exp_rdy});
            chk("in_ready_odd",  {63'd0, ir_o}, {63'd0, exp_rdy});
            chk("in_ready_sat",  {63'd0, ir_s}, {63'd0, exp_rdy});
        end
        if (r) begin
            q.delete();
            words  = 0;
            errs_e = 0;
            errs_o = 0;
        end else begin
            if (clr) begin
                words  = 0;
                errs_e = 0;
                errs_o = 0;
            end
            if (v && exp_rdy) begin
                e = ((($countones(d) + int'(p)) % 2) != 0);
                it.data = d;
                it.err_even = e;
                q.push_back(it);
                words++;
                if (e) errs_e++;
                else   errs_o++;
            end
        end
        @(posedge clk);
        if (r) started = 1'b1;
    endtask

    // Monitor: retire drained words, then compare held output and statistics
    always begin
        @(negedge clk);
        #3;
        cons = ov_e && out_ready && !rst;
        @(posedge clk);
        #2;
        if (started) begin
            if (cons && !rst && q.size() > 0) void'(q.pop_front());
            chk("out_valid_even", {63'd0, ov_e}, {63'd0, q.size() != 0});
            chk("out_valid_odd",  {63'd0, ov_o}, {63'd0, q.size() != 0});
            chk("out_valid_sat",  {63'd0, ov_s}, {63'd0, q.size() != 0});
            if (q.size() != 0 && ov_e) begin
                chk("out_data_even",  {56'd0, od_e}, {56'd0, q[0].data});
                chk("out_data_odd",   {56'd0, od_o}, {56'd0, q[0].data});
                chk("out_data_sat",   {56'd0, od_s}, {56'd0, q[0].data});
                chk("out_error_even", {63'd0, oe_e}, {63'd0, q[0].err_even});
                chk("out_error_odd",  {63'd0, oe_o}, {63'd0, !q[0].err_even});
                chk("out_error_sat",  {63'd0, oe_s}, {63'd0, q[0].err_even});
            end
            chk("word_count_even", {56'd0, wc_e}, 64'(sat(words, 255)));
            chk("err_count_even",  {56'd0, ec_e}, 64'(sat(errs_e, 255)));
            chk("sticky_even",     {63'd0, st_e}, {63'd0, errs_e > 0});
            chk("word_count_odd",  {56'd0, wc_o}, 64'(sat(words, 255)));
            chk("err_count_odd",   {56'd0, ec_o}, 64'(sat(errs_o, 255)));
            chk("sticky_odd",      {63'd0, st_o}, {63'd0, errs_o > 0});
            chk("word_count_sat",  {62'd0, wc_s}, 64'(sat(words, 3)));
            chk("err_count_sat",   {62'd0, ec_s}, 64'(sat(errs_e, 3)));
            chk("sticky_sat",      {63'd0, st_s}, {63'd0, errs_e > 0});
        end
    end

    // Directed scenarios, then randomized traffic
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_parity = 1'b0;
        out_ready = 1'b0; clr_stats = 1'b0;

        // Reset with a word offered
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        chk("reset_out_valid", {63'd0, ov_e}, 64'd0);
        chk("reset_word_count", {56'd0, wc_e}, 64'd0);
        chk("reset_in_ready", {63'd0, ir_e}, 64'd1);

        // Even parity: good word then bad word
        step(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("even_a5_error", {63'd0, oe_e}, 64'd0);
        chk("even_a5_data", {56'd0, od_e}, 64'hA5);
        step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("even_01_error", {63'd0, oe_e}, 64'd1);
        chk("even_err_count", {56'd0, ec_e}, 64'd1);
        chk("even_word_count", {56'd0, wc_e}, 64'd2);
        chk("even_sticky", {63'd0, st_e}, 64'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Backpressure
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("bp_hold_data", {56'd0, od_e}, 64'h3C);
        chk("bp_in_ready", {63'd0, ir_e}, 64'd0);
        step(1'b1, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("bp_next_data", {56'd0, od_e}, 64'h7E);
        chk("bp_next_valid", {63'd0, ov_e}, 64'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);

        // Odd parity
        step(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        chk("odd_00p1_error", {63'd0, oe_o}, 64'd0);
        step(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("odd_00p0_error", {63'd0, oe_o}, 64'd1);

        // Saturation of the 2-bit counters
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("sat_err_count", {62'd0, ec_s}, 64'd3);
        chk("sat_word_count", {62'd0, wc_s}, 64'd3);

        // Clear colliding with an erroneous word
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        #2;
        chk("clr_err_count", {56'd0, ec_e}, 64'd1);
        chk("clr_word_count", {56'd0, wc_e}, 64'd1);
        chk("clr_sticky", {63'd0, st_e}, 64'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 75), 8'($urandom), 1'($urandom),
                 1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 5),
                 1'($urandom_range(0, 99) < 2));
        end

        // Drain
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
